// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight,
// and buffers one instruction for downstream. Redirects can kill a pending response.
module fetch_unit #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned INST_W   = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned CNT_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [XLEN-1:0]   req_addr,
    input  logic              resp_valid,
    input  logic [INST_W-1:0] resp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT
    } state_e;

    localparam logic [XLEN-1:0] RESET_PC_X = XLEN'(RESET_PC);

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                kill_q, kill_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                misalign_q, misalign_d;
    logic [XLEN-1:0]     redirect_target;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // A redirect suppresses both handshakes in the cycle it is presented.
    assign req_valid  = (state_q == S_REQ) && !redirect_valid && !rst;
    assign inst_valid = (state_q == S_OUT) && !redirect_valid && !rst;

    assign req_addr     = pc_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign fetch_cnt    = cnt_q;
    assign misalign_err = misalign_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        cnt_d      = cnt_q;
        misalign_d = misalign_q;

        if (redirect_valid) begin
            pc_d = redirect_target;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            unique case (state_q)
                S_REQ: state_d = S_REQ;
                S_WAIT: begin
                    // A response landing with the redirect is the one to discard.
                    if (resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                S_OUT:   state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d    = resp_data;
                            inst_pc_d = pc_q;
                            state_d   = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        pc_d    = pc_q + XLEN'(4);
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC_X;
            // The pre-reset request may still answer; arm a kill for it.
            kill_q     <= (state_q == S_WAIT);
            inst_q     <= '0;
            inst_pc_q  <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and scoreboard bench for fetch_unit; a second instance with a
// 4-bit counter shares all inputs to exercise counter wrap.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_ready;

    logic        req_valid, inst_valid, misalign_err;
    logic [63:0] req_addr, inst_pc;
    logic [31:0] inst;
    logic [63:0] fetch_cnt;

    logic        req_valid_c4, inst_valid_c4, misalign_err_c4;
    logic [63:0] req_addr_c4, inst_pc_c4;
    logic [31:0] inst_c4;
    logic [3:0]  fetch_cnt_c4;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .fetch_cnt(fetch_cnt), .misalign_err(misalign_err)
    );

    fetch_unit #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_c4), .req_ready(req_ready), .req_addr(req_addr_c4),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid_c4), .inst_ready(inst_ready),
        .inst(inst_c4), .inst_pc(inst_pc_c4),
        .fetch_cnt(fetch_cnt_c4), .misalign_err(misalign_err_c4)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_deliv  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Downstream monitor: every accepted instruction must match the scoreboard.
    always @(negedge clk) begin
        #2;
        if (!rst && inst_valid && inst_ready) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("deliv_inst", 64'(inst), 64'(e.inst));
                check("deliv_pc", inst_pc, e.pc);
                check("deliv_cnt", fetch_cnt, 64'(n_deliv));
                check("deliv_cnt4", 64'(fetch_cnt_c4), 64'(n_deliv % 16));
            end
            n_deliv++;
        end
    end

    // Wait for a request at addr, accept it, answer after lat cycles.
    task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data,
                             input int lat, input logic rdy, input logic push);
        int   n = 0;
        exp_t e;
        req_ready  = 1'b1;
        inst_ready = rdy;
        resp_valid = 1'b0;
        #1;
        while (!req_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("req_valid", 64'(req_valid), 64'd1);
        check("req_addr", req_addr, addr);
        @(negedge clk);
        req_ready = 1'b0;
        repeat (lat - 1) @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = data;
        if (push) begin
            e.inst = data;
            e.pc   = addr;
            sb_q.push_back(e);
        end
        @(negedge clk);
        resp_valid = 1'b0;
        resp_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

        // Reset held two cycles; outputs gated while rst is high.
        @(negedge clk); #1;
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_addr", req_addr, 64'h8000_0000);
        check("rst_cnt", fetch_cnt, 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        @(negedge clk);

        // Basic fetch.
        fetch_one(64'h8000_0000, 32'h0010_0093, 1, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("t1_next_addr", req_addr, 64'h8000_0004);
        check("t1_cnt", fetch_cnt, 64'd1);
        check("t1_inst_valid", 64'(inst_valid), 64'd0);

        // Request backpressure; a stray response in S_REQ must be ignored.
        resp_valid = 1'b1;
        resp_data  = 32'hbad0_0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("t2_req_held", 64'(req_valid), 64'd1);
            check("t2_addr_held", req_addr, 64'h8000_0004);
        end
        @(negedge clk);
        resp_valid = 1'b0;
        fetch_one(64'h8000_0004, 32'h0020_0113, 1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_stall_valid", 64'(inst_valid), 64'd1);
            check("t2_stall_inst", 64'(inst), 64'h0020_0113);
            check("t2_stall_pc", inst_pc, 64'h8000_0004);
            check("t2_stall_cnt", fetch_cnt, 64'd1);
            @(negedge clk);
        end
        inst_ready = 1'b1;
        @(negedge clk); #1;
        check("t2_cnt", fetch_cnt, 64'd2);
        check("t2_next_addr", req_addr, 64'h8000_0008);

        // Redirect while waiting; the late response is killed.
        @(negedge clk);
        req_ready = 1'b1;
        #1 check("t3_addr", req_addr, 64'h8000_0008);
        @(negedge clk);
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = 32'hdead_beef;
        @(negedge clk);
        resp_valid = 1'b0;
        #1;
        check("t3_req_valid", 64'(req_valid), 64'd1);
        check("t3_target", req_addr, 64'h8000_1000);
        check("t3_no_inst", 64'(inst_valid), 64'd0);
        fetch_one(64'h8000_1000, 32'h0030_0193, 1, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("t3_cnt", fetch_cnt, 64'd3);

        // Redirect and response in the same S_WAIT cycle.
        @(negedge clk);
        req_ready = 1'b1;
        #1 check("t4_addr", req_addr, 64'h8000_1004);
        @(negedge clk);
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        resp_valid     = 1'b1;
        resp_data      = 32'hbad0_0002;
        @(negedge clk);
        redirect_valid = 1'b0;
        resp_valid     = 1'b0;
        #1;
        check("t4_req_valid", 64'(req_valid), 64'd1);
        check("t4_target", req_addr, 64'h8000_2000);

        // Redirect while an instruction is buffered in S_OUT.
        fetch_one(64'h8000_2000, 32'h0040_0213, 1, 1'b0, 1'b0);
        #1 check("t4_out_valid", 64'(inst_valid), 64'd1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        inst_ready     = 1'b1;
        #1 check("t4_out_killed", 64'(inst_valid), 64'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t4_cnt", fetch_cnt, 64'd3);
        check("t4_out_target", req_addr, 64'h8000_3000);

        // Misaligned redirect target.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0006;
        #1;
        check("t5_req_suppressed", 64'(req_valid), 64'd0);
        check("t5_misalign_before", 64'(misalign_err), 64'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("t5_aligned", req_addr, 64'h8000_0004);
        check("t5_misalign", 64'(misalign_err), 64'd1);
        fetch_one(64'h8000_0004, 32'h0060_0313, 1, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("t5_misalign_sticky", 64'(misalign_err), 64'd1);
        check("t5_cnt", fetch_cnt, 64'd4);

        // Reset in S_WAIT; the stale response after reset is discarded.
        @(negedge clk);
        req_ready = 1'b1;
        #1 check("t6_addr", req_addr, 64'h8000_0008);
        @(negedge clk);
        req_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("t6_rst_req", 64'(req_valid), 64'd0);
        check("t6_rst_inst", 64'(inst_valid), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        n_deliv = 0;
        #1;
        check("t6_cnt", fetch_cnt, 64'd0);
        check("t6_misalign", 64'(misalign_err), 64'd0);
        check("t6_inst", 64'(inst), 64'd0);
        check("t6_addr_reset", req_addr, 64'h8000_0000);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'hbad0_0003;
        @(negedge clk);
        resp_valid = 1'b0;
        #1;
        check("t6_stale_dropped", 64'(inst_valid), 64'd0);
        check("t6_rerequest", req_addr, 64'h8000_0000);
        fetch_one(64'h8000_0000, 32'h0070_0393, 1, 1'b1, 1'b1);

        // Sixteen more deliveries with varying memory latency: 17 total.
        for (int i = 1; i <= 16; i++) begin
            fetch_one(64'h8000_0000 + 64'(4 * i), $urandom, $urandom_range(1, 3), 1'b1, 1'b1);
        end
        @(negedge clk); #1;
        check("t7_cnt64", fetch_cnt, 64'd17);
        check("t7_cnt4_wrap", 64'(fetch_cnt_c4), 64'd1);
        check("t7_addr", req_addr, 64'h8000_0044);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
